// File: rtl/c4_timing_pkg.sv
// Shared timing definitions for the Connect4 delay engine: FSM encoding,
// default sizes and a width helper.
package c4_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } c4_state_e;

  localparam int C4_PRESCALE_DEFAULT = 65001;
  localparam int C4_LEN_W            = 8;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int c4_clog2(input int value);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << w) < value) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly above ptr_in,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import c4_timing_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = c4_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [PTR_W-1:0]   ptr_in,
  output logic [NUM_REQ-1:0] gnt_out
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    gnt_out = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr_in) + k) % NUM_REQ);
      if (!w_found && req_in[w_idx]) begin
        gnt_out[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Shared prescaler + delay counter, handed round-robin to NUM_REQ requesters.
// Optional feature macro: DLY_ABORT_EN adds abort_in for owner-side cancellation.
module delay_arbiter
  import c4_timing_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int LEN_W    = C4_LEN_W,
  parameter int PRESCALE = C4_PRESCALE_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*LEN_W-1:0] len_in,
`ifdef DLY_ABORT_EN
  input  logic [NUM_REQ-1:0]       abort_in,
`endif
  output logic [NUM_REQ-1:0]       gnt_out,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     busy_out
);

  localparam int PTR_W = c4_clog2(NUM_REQ);
  localparam int PRE_W = c4_clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  c4_state_e          r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic [PTR_W-1:0]   r_ptr;
  logic [PRE_W-1:0]   r_pre;
  logic [LEN_W-1:0]   r_rem;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PTR_W-1:0]   w_win;
  logic [LEN_W-1:0]   w_len;
  logic               w_abort;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_in  (req_in),
    .ptr_in  (r_ptr),
    .gnt_out (w_arb_gnt)
  );

  always_comb begin
    w_win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_arb_gnt[k]) w_win = PTR_W'(k);
    end
  end

  // After a grant r_ptr is the owner, so it also selects the owner's length/abort.
  assign w_len = len_in[int'(r_ptr)*LEN_W +: LEN_W];

`ifdef DLY_ABORT_EN
  assign w_abort = abort_in[r_ptr];
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_pre   <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_in) begin
            r_gnt   <= w_arb_gnt;
            r_ptr   <= w_win;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_abort) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_rem   <= (w_len == '0) ? LEN_W'(1) : w_len;
            r_pre   <= '0;
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (w_abort) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_pre   <= '0;
            r_rem   <= '0;
            r_state <= ST_IDLE;
          end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) r_state <= ST_DONE;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        ST_DONE: begin
          // First DONE cycle arms the registered pulse; the grant drops as it ends.
          if (r_done == '0) begin
            r_done <= r_gnt;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_out  = r_gnt;
  assign done_out = r_done;
  assign busy_out = r_busy;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter (PRESCALE=4, NUM_REQ=2, LEN_W=8) with a
// timing-formula reference model; build with DLY_ABORT_EN to cover abort.
module tb_delay_arbiter;

  localparam int N  = 2;
  localparam int LW = 8;
  localparam int P  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] len = '0;
`ifdef DLY_ABORT_EN
  logic [N-1:0]    abort = '0;
`endif
  logic [N-1:0]    gnt_out;
  logic [N-1:0]    done_out;
  logic            busy_out;

  delay_arbiter #(.NUM_REQ(N), .LEN_W(LW), .PRESCALE(P)) dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .req_in   (req),
    .len_in   (len),
`ifdef DLY_ABORT_EN
    .abort_in (abort),
`endif
    .gnt_out  (gnt_out),
    .done_out (done_out),
    .busy_out (busy_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int edge_cnt = 0;
  int n_done0 = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a grant at edge k owns the engine for L*P+3 edges;
  // done is expected in the cycle starting at edge k+L*P+2.
  int m_busy = 0, m_owner = 0, m_t = 0, m_L = 1, m_ptr = N - 1;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int off = 1; off <= N; off++) begin
      if (r[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic int len_of(input int idx);
    int v;
    v = int'(len[idx*LW +: LW]);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_t <= 0; m_ptr <= N - 1;
    end else if (m_busy != 0) begin
      if (
`ifdef DLY_ABORT_EN
          abort[m_owner] && (m_t == 0 || m_t <= m_L * P)
`else
          1'b0
`endif
         ) begin
        m_busy <= 0;
      end else begin
        if (m_t == 0) m_L <= len_of(m_owner);
        m_t <= m_t + 1;
        if (m_t != 0 && m_t + 1 == m_L * P + 3) m_busy <= 0;
      end
    end else if (req != '0) begin
      m_owner <= pick(req, m_ptr);
      m_ptr   <= pick(req, m_ptr);
      m_busy  <= 1;
      m_t     <= 0;
    end
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    int exp_v;
    exp_v = (m_busy != 0) ? (((1 << m_owner) << 3) | 1) : 0;
    if (m_busy != 0 && m_t == m_L * P + 2) exp_v = exp_v | ((1 << m_owner) << 1);
    if (cmp_en) check("cycle {gnt,done,busy}", int'({gnt_out, done_out, busy_out}), exp_v);
    if (done_out[0]) n_done0 <= n_done0 + 1;
  end

  task automatic wait_done(input int idx, input int max_cyc, output int e);
    e = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done_out[idx]) begin e = edge_cnt; return; end
    end
  endtask

  task automatic wait_gnt(input logic [N-1:0] val, input int max_cyc, output int e);
    e = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (gnt_out == val) begin e = edge_cnt; return; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k, e, e2, a, hi, d0;
    // 1. reset state and idle behaviour
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset gnt", int'(gnt_out), 0);
    check("reset done", int'(done_out), 0);
    check("reset busy", int'(busy_out), 0);
    rst_n = 1'b1;
    hi = 0;
    repeat (20) begin @(negedge clk); if (busy_out) hi++; end
    check("idle busy cycles", hi, 0);

    // 2. single request, len 3
    len = {8'd0, 8'd3}; req = 2'b01; k = edge_cnt + 1;
    @(negedge clk);
    check("t2 gnt at k", int'(gnt_out), 1);
    wait_done(0, 40, e);
    check("t2 done edge offset", e - k, 14);
    @(negedge clk);
    req = 2'b00;
    check("t2 done single cycle", int'(done_out), 0);
    check("t2 gnt released", int'(gnt_out), 0);
    repeat (3) @(negedge clk);

    // 3. simultaneous requests, len 1, alternation while held
    do_reset();
    len = {8'd1, 8'd1}; req = 2'b11; k = edge_cnt + 1;
    wait_done(0, 20, e);  check("t3 done0 offset", e - k, 6);
    wait_gnt(2'b10, 20, e); check("t3 gnt1 offset", e - k, 8);
    wait_done(1, 20, e);  check("t3 done1 offset", e - k, 14);
    wait_gnt(2'b01, 20, e); check("t3 gnt0 again offset", e - k, 16);
    req = 2'b00;
    wait_done(0, 20, e);  check("t3 done0 again offset", e - k, 22);
    repeat (3) @(negedge clk);

    // 4. len 0 acts as 1; len 255 with mid-count change ignored
    len = {8'd0, 8'd0}; req = 2'b01; k = edge_cnt + 1;
    wait_done(0, 20, e); check("t4 len0 offset", e - k, 6);
    @(negedge clk); req = 2'b00;
    repeat (3) @(negedge clk);
    len = {8'd0, 8'd255}; req = 2'b01; k = edge_cnt + 1;
    repeat (10) @(negedge clk);
    len = {8'd0, 8'd1};
    wait_done(0, 1100, e); check("t4 len255 offset", e - k, 1022);
    @(negedge clk); req = 2'b00;
    repeat (3) @(negedge clk);

    // 5. reset mid-count, then a fresh request
    len = {8'd0, 8'd5}; req = 2'b01;
    repeat (8) @(negedge clk);
    check("t5 busy before reset", int'(busy_out), 1);
    #2 rst_n = 1'b0; req = 2'b00;
    #1 check("t5 outputs in reset", int'({gnt_out, done_out, busy_out}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    len = {8'd0, 8'd2}; req = 2'b01; k = edge_cnt + 1;
    wait_done(0, 30, e); check("t5 fresh done offset", e - k, 10);
    @(negedge clk); req = 2'b00;
    repeat (3) @(negedge clk);

    // 6. owner abort (or completion without the feature), req1 pending
    len = {8'd1, 8'd3}; req = 2'b01; k = edge_cnt + 1;
    repeat (5) @(negedge clk);
    req = 2'b11;
    d0 = n_done0;
`ifdef DLY_ABORT_EN
    abort = 2'b01; a = edge_cnt + 1;
    @(negedge clk);
    abort = 2'b00;
    check("t6 gnt cleared by abort", int'(gnt_out), 0);
    wait_gnt(2'b10, 10, e); check("t6 gnt1 after abort", e - a, 1);
    req = 2'b10;
    wait_done(1, 20, e2); check("t6 done1 offset", e2 - e, 6);
    check("t6 no done0 pulse", n_done0 - d0, 0);
`else
    a = k;
    wait_done(0, 40, e); check("t6 done0 offset", e - a, 14);
    @(negedge clk); req = 2'b10;
    wait_gnt(2'b10, 10, e); check("t6 gnt1 offset", e - a, 16);
    wait_done(1, 20, e2); check("t6 done1 offset", e2 - a, 22);
    check("t6 one done0 pulse", n_done0 - d0, 1);
`endif
    @(negedge clk); req = 2'b00;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
